// File: rtl/rf_wport_arbiter_if.sv
// rtl/rf_wport_arbiter_if.sv - write-port arbiter bus: WB, long-latency result, issue and regfile sides
interface rf_wport_arbiter_if;
    logic        wb_we;
    logic [4:0]  wb_wn;
    logic [31:0] wb_d;
    logic        wb_hold;
    logic        mdu_valid;
    logic [4:0]  mdu_wn;
    logic [31:0] mdu_d;
    logic        mdu_ready;
    logic        iss_valid;
    logic [4:0]  iss_wn;
    logic        rf_we;
    logic [4:0]  rf_wn;
    logic [31:0] rf_d;
    logic [31:0] pend_mask;

    modport master (
        output wb_we, wb_wn, wb_d, mdu_valid, mdu_wn, mdu_d, iss_valid, iss_wn,
        input  wb_hold, mdu_ready, rf_we, rf_wn, rf_d, pend_mask
    );

    modport slave (
        input  wb_we, wb_wn, wb_d, mdu_valid, mdu_wn, mdu_d, iss_valid, iss_wn,
        output wb_hold, mdu_ready, rf_we, rf_wn, rf_d, pend_mask
    );
endinterface

// File: rtl/rf_wport_arbiter.sv
// rtl/rf_wport_arbiter.sv - regfile write-port arbiter: WB vs queued long-latency results, aging drain, scoreboard
// Optional same-cycle result bypass when RFWARB_BYPASS_EN is defined.
module rf_wport_arbiter #(
    parameter int DEPTH   = 4,
    parameter int MAXWAIT = 8
) (
    input  logic                clk,
    input  logic                clrn,
    rf_wport_arbiter_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(MAXWAIT + 1);
    localparam logic [WW-1:0] WMAX  = WW'(MAXWAIT);
    localparam logic [AW:0]   FULLC = (AW+1)'(DEPTH);

    logic [4:0]    q_wn [DEPTH];
    logic [31:0]   q_d  [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic [WW-1:0] wait_cnt;
    logic [31:0]   pend;
    logic [31:0]   pend_next;

    logic nonempty, full, wb_req, force_drain, bypass, push, pop;
    logic [4:0]  head_wn;
    logic [31:0] head_d;

    always_comb begin
        nonempty    = (count != '0);
        full        = (count == FULLC);
        wb_req      = bus.wb_we & (bus.wb_wn != 5'd0);
        force_drain = nonempty & (wait_cnt == WMAX);
        head_wn     = q_wn[rd_ptr];
        head_d      = q_d[rd_ptr];
`ifdef RFWARB_BYPASS_EN
        bypass      = ~nonempty & ~wb_req & bus.mdu_valid & (bus.mdu_wn != 5'd0);
`else
        bypass      = 1'b0;
`endif
        // An empty FIFO is never full, so ready already holds in the bypass case.
        bus.mdu_ready = ~full;
        push          = bus.mdu_valid & ~full & (bus.mdu_wn != 5'd0) & ~bypass;
        pop           = force_drain | (~wb_req & nonempty);
        bus.wb_hold   = force_drain & wb_req;

        bus.rf_we = 1'b0;
        bus.rf_wn = 5'd0;
        bus.rf_d  = 32'd0;
        if (pop) begin
            bus.rf_we = 1'b1;
            bus.rf_wn = head_wn;
            bus.rf_d  = head_d;
        end else if (wb_req) begin
            bus.rf_we = 1'b1;
            bus.rf_wn = bus.wb_wn;
            bus.rf_d  = bus.wb_d;
        end else if (bypass) begin
            bus.rf_we = 1'b1;
            bus.rf_wn = bus.mdu_wn;
            bus.rf_d  = bus.mdu_d;
        end

        // Set after clear so a same-cycle reissue keeps the bit.
        pend_next = pend;
        if (pop)
            pend_next = pend_next & ~(32'd1 << head_wn);
        if (bypass)
            pend_next = pend_next & ~(32'd1 << bus.mdu_wn);
        if (bus.iss_valid)
            pend_next = pend_next | (32'd1 << bus.iss_wn);
        pend_next[0] = 1'b0;

        bus.pend_mask = pend;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            wait_cnt <= '0;
            pend     <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (!nonempty || pop)
                wait_cnt <= '0;
            else if (wait_cnt != WMAX)
                wait_cnt <= wait_cnt + 1'b1;
            pend <= pend_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_wn[wr_ptr] <= bus.mdu_wn;
            q_d[wr_ptr]  <= bus.mdu_d;
        end
    end
endmodule
